imem_dmem_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the fetch stage (IF) and the memory stage (DM) of the RV32I pipeline.
- Serialises requests with one outstanding transaction, DM priority and a starvation guard for IF.
- Produces per-requester stall signals for the hazard unit.
- Sits between the IF/MEM stages and the memory wrapper.

---
 rtl/imem_dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-port memory between fetch (IF) and data (DM) requesters.
// Optional response watchdog with bus_err pulse enabled by defining ARB_TIMEOUT_EN.
module imem_dmem_arbiter #(
    parameter int XLEN           = 32,
    parameter int MAX_DM_STREAK  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_valid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [3:0]      dm_be,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    output logic            dm_valid,
    output logic [XLEN-1:0] dm_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall_if,
    output logic            stall_mem,
    output logic            bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

    if (MAX_DM_STREAK < 1 || MAX_DM_STREAK > 15) begin : g_bad_streak
        $error("MAX_DM_STREAK must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_owner;
    logic [3:0]      r_streak;
    logic [3:0]      w_streak_nxt;
    logic            r_we;
    logic [3:0]      r_be;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;

    logic w_streak_full;
    logic w_sel_dm;
    logic w_sel_if;
    logic w_load;
    logic w_timeout;
    logic w_done;
    logic w_fin;

    // DM normally wins; IF is forced once DM has won MAX_DM_STREAK times in a row.
    assign w_streak_full = (r_streak == STREAK_MAX);
    assign w_sel_dm      = dm_req & ~(if_req & w_streak_full);
    assign w_sel_if      = ~w_sel_dm & if_req;
    assign w_load        = (r_state == IDLE) & (w_sel_dm | w_sel_if);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_tcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt <= '0;
        end else if (r_state != RESP) begin
            r_tcnt <= '0;
        end else if (!mem_rvalid) begin
            r_tcnt <= r_tcnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == RESP) & ~mem_rvalid & (r_tcnt == TMO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_done = (r_state == RESP) & (mem_rvalid | w_timeout);

    always_comb begin
        w_state_nxt  = r_state;
        w_streak_nxt = r_streak;
        case (r_state)
            IDLE: begin
                if (w_sel_dm | w_sel_if) begin
                    w_state_nxt = REQ;
                end
                if (w_sel_if || !if_req) begin
                    w_streak_nxt = '0;
                end else if (w_sel_dm && !w_streak_full) begin
                    w_streak_nxt = r_streak + 4'd1;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_owner  <= 1'b0;
            r_streak <= '0;
            r_we     <= 1'b0;
            r_be     <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_streak <= w_streak_nxt;
            if (w_load) begin
                r_owner <= w_sel_dm;
                r_we    <= w_sel_dm & dm_we;
                r_be    <= w_sel_dm ? dm_be : 4'hF;
                r_addr  <= w_sel_dm ? dm_addr : if_addr;
                r_wdata <= w_sel_dm ? dm_wdata : '0;
            end
        end
    end

    assign mem_req   = (r_state == REQ);
    assign mem_we    = r_we;
    assign mem_be    = r_be;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    // Reset must suppress a response that lands in the same cycle.
    assign w_fin     = ~reset & w_done;
    assign if_valid  = w_fin & ~r_owner;
    assign dm_valid  = w_fin & r_owner;
    assign if_rdata  = w_timeout ? '0 : mem_rdata;
    assign dm_rdata  = w_timeout ? '0 : mem_rdata;
    assign bus_err   = ~reset & w_timeout;

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_valid;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: requester drivers, memory responder, monitor.
// Timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_imem_dmem_arbiter;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct packed {
        logic [31:0] data;
        logic        chk;
        logic        berr;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;

    always #5 clk = ~clk;

    imem_dmem_arbiter #(
        .XLEN(32),
        .MAX_DM_STREAK(4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_valid(if_valid),
        .if_rdata(if_rdata),
        .dm_req(dm_req),
        .dm_we(dm_we),
        .dm_be(dm_be),
        .dm_addr(dm_addr),
        .dm_wdata(dm_wdata),
        .dm_valid(dm_valid),
        .dm_rdata(dm_rdata),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_be(mem_be),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .stall_if(stall_if),
        .stall_mem(stall_mem),
        .bus_err(bus_err)
    );

    txn_t if_cmd_q[$];
    txn_t dm_cmd_q[$];
    txn_t iss_q[$];
    rsp_t if_exp_q[$];
    rsp_t dm_exp_q[$];

    int n_pass  = 0;
    int n_total = 0;

    bit if_busy   = 1'b0;
    bit dm_busy   = 1'b0;
    bit if_v_seen = 1'b0;
    bit dm_v_seen = 1'b0;

    int          gnt_delay = 0;
    int          rv_delay  = 0;
    bit          rv_en     = 1'b1;
    bit          resp_pend = 1'b0;
    int          gcnt      = 0;
    int          rcnt      = 0;
    logic [31:0] resp_data = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_evt(string name);
        n_total++;
        $display("FAIL %s: got event expected none", name);
    endtask

    function automatic logic [31:0] model_rd(logic [31:0] a);
        case (a)
            32'h10:  return 32'h0000_0093;
            32'h20:  return 32'h0050_0113;
            32'h30:  return 32'h1111_1111;
            32'h100: return 32'hCAFE_F00D;
            default: return {16'h0BAD, a[15:0]};
        endcase
    endfunction

    // Requester drivers: hold req until valid, then drop or issue next command.
    initial begin
        txn_t t;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_be    = '0;
        dm_addr  = '0;
        dm_wdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                if_busy = 1'b0;
                dm_busy = 1'b0;
            end else begin
                if (if_busy && if_v_seen) if_busy = 1'b0;
                if (dm_busy && dm_v_seen) dm_busy = 1'b0;
                if (!if_busy && if_cmd_q.size() > 0) begin
                    t       = if_cmd_q.pop_front();
                    if_addr = t.addr;
                    if_busy = 1'b1;
                end
                if (!dm_busy && dm_cmd_q.size() > 0) begin
                    t        = dm_cmd_q.pop_front();
                    dm_we    = t.we;
                    dm_be    = t.be;
                    dm_addr  = t.addr;
                    dm_wdata = t.wdata;
                    dm_busy  = 1'b1;
                end
            end
            if_req = if_busy;
            dm_req = dm_busy;
        end
    end

    // Memory responder.
    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h5A5A_A5A5;
            if (resp_pend) begin
                if (rv_en && rcnt == rv_delay) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = resp_data;
                    resp_pend  = 1'b0;
                end else begin
                    rcnt++;
                end
            end else if (mem_req) begin
                if (gcnt == gnt_delay) begin
                    mem_gnt   = 1'b1;
                    gcnt      = 0;
                    rcnt      = 0;
                    resp_pend = 1'b1;
                    resp_data = model_rd(mem_addr);
                end else begin
                    gcnt++;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        rsp_t e;
        txn_t t;
        forever begin
            @(negedge clk);
            if_v_seen = if_valid;
            dm_v_seen = dm_valid;
            if (if_valid && dm_valid) fail_evt("both_valid");
            if (if_valid) begin
                if (if_exp_q.size() == 0) fail_evt("if_valid_unexpected");
                else begin
                    e = if_exp_q.pop_front();
                    if (e.chk) chk("if_rdata", if_rdata, e.data);
                    chk("if_bus_err", {31'd0, bus_err}, {31'd0, e.berr});
                end
            end
            if (dm_valid) begin
                if (dm_exp_q.size() == 0) fail_evt("dm_valid_unexpected");
                else begin
                    e = dm_exp_q.pop_front();
                    if (e.chk) chk("dm_rdata", dm_rdata, e.data);
                    chk("dm_bus_err", {31'd0, bus_err}, {31'd0, e.berr});
                end
            end
            if (mem_req && mem_gnt) begin
                if (iss_q.size() == 0) fail_evt("issue_unexpected");
                else begin
                    t = iss_q.pop_front();
                    chk("issue_addr", mem_addr, t.addr);
                    chk("issue_we_be", {27'd0, mem_we, mem_be}, {27'd0, t.we, t.be});
                    if (t.we) chk("issue_wdata", mem_wdata, t.wdata);
                end
            end
            if (bus_err && !if_valid && !dm_valid) fail_evt("bus_err_stray");
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic wait_idle(string name, int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!if_busy && !dm_busy && !mem_req &&
                if_cmd_q.size() == 0 && dm_cmd_q.size() == 0 &&
                if_exp_q.size() == 0 && dm_exp_q.size() == 0 &&
                iss_q.size() == 0)
                done = 1'b1;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    task automatic push_if(logic [31:0] a, logic [31:0] d);
        txn_t t;
        t = '{we: 1'b0, be: 4'hF, addr: a, wdata: 32'd0};
        if_cmd_q.push_back(t);
        if_exp_q.push_back('{data: d, chk: 1'b1, berr: 1'b0});
    endtask

    task automatic push_dm(logic we, logic [3:0] be, logic [31:0] a,
                           logic [31:0] wd, logic [31:0] d, logic ck,
                           logic be_err);
        txn_t t;
        t = '{we: we, be: be, addr: a, wdata: wd};
        dm_cmd_q.push_back(t);
        dm_exp_q.push_back('{data: d, chk: ck, berr: be_err});
    endtask

    task automatic exp_issue(logic we, logic [3:0] be, logic [31:0] a, logic [31:0] wd);
        txn_t t;
        t = '{we: we, be: be, addr: a, wdata: wd};
        iss_q.push_back(t);
    endtask

    initial begin
        int  cnt;
        bit  bad;
        bit  seen;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we_be", {27'd0, mem_we, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_valids", {30'd0, if_valid, dm_valid}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Lone fetch with exact cycle timing.
        push_if(32'h10, 32'h0000_0093);
        exp_issue(1'b0, 4'hF, 32'h10, 32'd0);
        @(negedge clk);
        chk("t1_c0_stall_if", {31'd0, stall_if}, 32'd1);
        chk("t1_c0_mem_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        chk("t1_c1_mem_req", {31'd0, mem_req}, 32'd1);
        chk("t1_c1_mem_addr", mem_addr, 32'h10);
        chk("t1_c1_mem_be", {28'd0, mem_be}, 32'hF);
        chk("t1_c1_stall_if", {31'd0, stall_if}, 32'd1);
        @(negedge clk);
        chk("t1_c2_if_valid", {31'd0, if_valid}, 32'd1);
        chk("t1_c2_stall_if", {31'd0, stall_if}, 32'd0);
        wait_idle("t1_idle", 20);

        // Simultaneous IF and DM: DM first, IF stalled throughout.
        push_if(32'h20, 32'h0050_0113);
        push_dm(1'b0, 4'hF, 32'h100, 32'd0, 32'hCAFE_F00D, 1'b1, 1'b0);
        exp_issue(1'b0, 4'hF, 32'h100, 32'd0);
        exp_issue(1'b0, 4'hF, 32'h20, 32'd0);
        bad  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (if_valid) seen = 1'b1;
            else if (!stall_if) bad = 1'b1;
        end
        chk("t2_if_valid_seen", {31'd0, seen}, 32'd1);
        chk("t2_stall_if_held", {31'd0, bad}, 32'd0);
        wait_idle("t2_idle", 20);

        // DM stream with IF held: 4 DM, then IF, then DM resumes.
        for (int i = 0; i < 6; i++) begin
            push_dm(1'b1, 4'hF, 32'h300 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1),
                    32'd0, 1'b0, 1'b0);
        end
        push_if(32'h10, 32'h0000_0093);
        for (int i = 0; i < 4; i++)
            exp_issue(1'b1, 4'hF, 32'h300 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
        exp_issue(1'b0, 4'hF, 32'h10, 32'd0);
        for (int i = 4; i < 6; i++)
            exp_issue(1'b1, 4'hF, 32'h300 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
        wait_idle("t3_idle", 80);

        // Store with delayed grant: request fields stable across REQ.
        gnt_delay = 3;
        push_dm(1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
        exp_issue(1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF);
        cnt = 0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) begin
                cnt++;
                if ({mem_we, mem_be, mem_addr, mem_wdata} !==
                    {1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF}) bad = 1'b1;
            end else if (cnt > 0) begin
                break;
            end
        end
        chk("t4_req_cycles", 32'(cnt), 32'd4);
        chk("t4_req_stable", {31'd0, bad}, 32'd0);
        wait_idle("t4_idle", 20);
        gnt_delay = 0;

        // Reset during RESP, late rvalid afterwards is ignored.
        rv_delay = 5;
        push_if(32'h30, 32'h1111_1111);
        exp_issue(1'b0, 4'hF, 32'h30, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_gnt && mem_req) seen = 1'b1;
        end
        chk("t5_gnt_seen", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("t5_rst_valids", {30'd0, if_valid, dm_valid}, 32'd0);
        if_exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t5_post_mem_req", {31'd0, mem_req}, 32'd0);
        chk("t5_post_mem_addr", mem_addr, 32'd0);
        chk("t5_post_mem_we_be", {27'd0, mem_we, mem_be}, 32'd0);
        chk("t5_post_stall_if", {31'd0, stall_if}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_rvalid) begin
                seen = 1'b1;
                chk("t5_late_valids", {30'd0, if_valid, dm_valid}, 32'd0);
                chk("t5_late_mem_req", {31'd0, mem_req}, 32'd0);
            end
        end
        chk("t5_late_rvalid_seen", {31'd0, seen}, 32'd1);
        rv_delay = 0;
        wait_idle("t5_idle", 20);

`ifdef ARB_TIMEOUT_EN
        // Memory never answers: watchdog closes the transaction.
        rv_en = 1'b0;
        push_dm(1'b0, 4'hF, 32'h140, 32'd0, 32'd0, 1'b1, 1'b1);
        exp_issue(1'b0, 4'hF, 32'h140, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_gnt && mem_req) seen = 1'b1;
        end
        chk("t6_gnt_seen", {31'd0, seen}, 32'd1);
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            cnt++;
            if (dm_valid) seen = 1'b1;
        end
        chk("t6_resp_cycles", 32'(cnt), 32'd8);
        @(negedge clk);
        chk("t6_bus_err_pulse", {31'd0, bus_err}, 32'd0);
        resp_pend = 1'b0;
        rv_en     = 1'b1;
        push_dm(1'b0, 4'hF, 32'h10, 32'd0, 32'h0000_0093, 1'b1, 1'b0);
        exp_issue(1'b0, 4'hF, 32'h10, 32'd0);
        wait_idle("t6_idle", 20);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
